// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame constants and baud-count helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    // Same divisor uart_tx uses, so both ends agree on the bit period.
    function automatic int baud_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose: two-flop synchronizer for the RX pin plus a delay flop for falling-edge detect.
// Latency: rxd_sync lags the pin by 2 clk; fall asserts 2 clk after the pin drops.
// Backpressure: none, free-running.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_sync,
    output logic fall
);

    logic rxd_s1;
    logic rxd_s2;
    logic rxd_d;

    // Reset to the idle-high line level so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign rxd_sync = rxd_s2;
    assign fall     = rxd_d & ~rxd_s2;

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver, LSB first, mid-bit sampling; done/ferr strobes per frame.
// Latency: done about 3 + 9*BAUD_CNT_MAX + SAMPLE_PT clk after the line's falling edge.
// Backpressure: none; the consumer must take each byte within one frame time.
module uart_rx #(
    parameter int UART_BPS = 115200,
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_done,
    output logic       uart_rx_busy,
    output logic       uart_rx_ferr
);

    import uart_pkg::*;

    localparam int BAUD_CNT_MAX = baud_cnt(CLK_FREQ, UART_BPS);
    localparam int SAMPLE_PT    = BAUD_CNT_MAX / 2;
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [15:0]      CNT_SAMPLE = 16'(SAMPLE_PT);
    localparam logic [15:0]      CNT_LAST   = 16'(BAUD_CNT_MAX - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);

    logic                 rxd_s2;
    logic                 fall;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [15:0]          bd_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 at_sample;
    logic                 at_wrap;
    logic                 frame_ok;
    logic                 frame_bad;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rxd      (uart_rxd),
        .rxd_sync (rxd_s2),
        .fall     (fall)
    );

    assign at_sample = (bd_cnt == CNT_SAMPLE);
    assign at_wrap   = (bd_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                // A line that is high again at mid-start was a glitch, not a frame.
                if (at_sample && rxd_s2) begin
                    state_nxt = IDLE;
                end else if (at_wrap) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_wrap && (bit_cnt == BIT_LAST)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so a shortened transmitter stop bit is not missed.
                if (at_sample) begin
                    state_nxt = IDLE;
                    frame_ok  = (rxd_s2 == STOP_LEVEL);
                    frame_bad = (rxd_s2 != STOP_LEVEL);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bd_cnt       <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            uart_rx_data <= '0;
            uart_rx_done <= 1'b0;
            uart_rx_ferr <= 1'b0;
        end else begin
            if ((state == IDLE) || (state_nxt == IDLE) || at_wrap) begin
                bd_cnt <= '0;
            end else begin
                bd_cnt <= bd_cnt + 16'd1;
            end

            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (at_wrap) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if ((state == DATA) && at_sample) begin
                shift_reg[bit_cnt] <= rxd_s2;
            end

            if (frame_ok) begin
                uart_rx_data <= shift_reg;
            end
            uart_rx_done <= frame_ok;
            uart_rx_ferr <= frame_bad;
        end
    end

    assign uart_rx_busy = (state != IDLE);

endmodule
